// File: rtl/k423_ex_alu_mc.sv
// k423 execute-stage integer unit: single-cycle RV ALU ops plus an iterative
// one-bit-per-cycle multiply/divide engine behind a valid/ready handshake.
module k423_ex_alu_mc #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      op_i,
    input  logic            use_imm_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] rd_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLT    = 5'd2;
    localparam logic [4:0] OP_SLTU   = 5'd3;
    localparam logic [4:0] OP_AND    = 5'd4;
    localparam logic [4:0] OP_OR     = 5'd5;
    localparam logic [4:0] OP_XOR    = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_LUI    = 5'd10;
    localparam logic [4:0] OP_AUIPC  = 5'd11;
    localparam logic [4:0] OP_MUL    = 5'd12;
    localparam logic [4:0] OP_MULH   = 5'd13;
    localparam logic [4:0] OP_MULHSU = 5'd14;
    localparam logic [4:0] OP_DIV    = 5'd16;
    localparam logic [4:0] OP_DIVU   = 5'd17;
    localparam logic [4:0] OP_REM    = 5'd18;
    localparam logic [4:0] OP_REMU   = 5'd19;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_b;
    logic [2:0]       r_op;
    logic             r_neg;
    logic             r_ovr;
    logic [XLEN-1:0]  r_ovr_val;
    logic [XLEN-1:0]  r_rd;
    logic             r_out_valid;

    logic [XLEN-1:0]  w_op1;
    logic [XLEN-1:0]  w_op2;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]  w_alu;
    logic             w_is_mc;
    logic             w_accept;
    logic             w_s1;
    logic             w_s2;
    logic             w_n1;
    logic             w_n2;
    logic [XLEN-1:0]  w_mag1;
    logic [XLEN-1:0]  w_mag2;
    logic             w_div0;
    logic             w_sovf;
    logic [XLEN-1:0]  w_ovr_val;
    logic [XLEN:0]    w_add;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_diff;
    logic [XLEN-1:0]  w_step_hi;
    logic [XLEN-1:0]  w_step_lo;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]  w_fix;

    assign w_op1    = (op_i == OP_AUIPC) ? pc_i : rs1_i;
    assign w_op2    = use_imm_i ? imm_i : rs2_i;
    assign w_shamt  = w_op2[SHAMT_W-1:0];
    assign w_is_mc  = (op_i >= OP_MUL) && (op_i <= OP_REMU);

    assign in_ready_o  = (r_state == ST_IDLE) && (!r_out_valid || out_ready_i);
    assign w_accept    = in_valid_i && in_ready_o && !flush_i;
    assign out_valid_o = r_out_valid;
    assign rd_o        = r_rd;
    assign busy_o      = (r_state != ST_IDLE);

    always_comb begin
        w_alu = '0;
        case (op_i)
            OP_ADD:   w_alu = w_op1 + w_op2;
            OP_SUB:   w_alu = w_op1 - w_op2;
            OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
            OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_op1 < w_op2)};
            OP_AND:   w_alu = w_op1 & w_op2;
            OP_OR:    w_alu = w_op1 | w_op2;
            OP_XOR:   w_alu = w_op1 ^ w_op2;
            OP_SLL:   w_alu = w_op1 << w_shamt;
            OP_SRL:   w_alu = w_op1 >> w_shamt;
            OP_SRA:   w_alu = $unsigned($signed(w_op1) >>> w_shamt);
            OP_LUI:   w_alu = imm_i;
            OP_AUIPC: w_alu = w_op1 + w_op2;
            default:  w_alu = '0;
        endcase
    end

    // Signedness per op; the engine always works on magnitudes.
    assign w_s1   = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign w_s2   = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign w_n1   = w_s1 && w_op1[XLEN-1];
    assign w_n2   = w_s2 && w_op2[XLEN-1];
    assign w_mag1 = w_n1 ? (~w_op1 + 1'b1) : w_op1;
    assign w_mag2 = w_n2 ? (~w_op2 + 1'b1) : w_op2;

    assign w_div0 = (op_i >= OP_DIV) && (op_i <= OP_REMU) && (w_op2 == '0);
    assign w_sovf = ((op_i == OP_DIV) || (op_i == OP_REM)) && (w_op1 == MOST_NEG) && (&w_op2);

    always_comb begin
        w_ovr_val = '0;
        if (w_div0)
            w_ovr_val = ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? {XLEN{1'b1}} : w_op1;
        else if (w_sovf)
            w_ovr_val = (op_i == OP_DIV) ? MOST_NEG : '0;
    end

    // r_hi is the accumulator / partial remainder, r_lo the multiplier / quotient.
    assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_b};

    always_comb begin
        w_step_hi = w_add[XLEN:1];
        w_step_lo = {w_add[0], r_lo[XLEN-1:1]};
        if (r_op[2]) begin
            if (!w_diff[XLEN]) begin
                w_step_hi = w_diff[XLEN-1:0];
                w_step_lo = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_step_hi = w_shift[XLEN-1:0];
                w_step_lo = {r_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign w_prod_s = r_neg ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};

    always_comb begin
        w_fix = '0;
        case (r_op)
            3'd0:       w_fix = w_prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       w_fix = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: w_fix = r_neg ? (~r_lo + 1'b1) : r_lo;
            default:    w_fix = r_neg ? (~r_hi + 1'b1) : r_hi;
        endcase
        if (r_ovr)
            w_fix = r_ovr_val;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_neg       <= 1'b0;
            r_ovr       <= 1'b0;
            r_ovr_val   <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
        end else if (flush_i) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready_i)
                r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mc) begin
                            r_state   <= ST_ITER;
                            r_count   <= '0;
                            r_hi      <= '0;
                            r_lo      <= w_mag1;
                            r_b       <= w_mag2;
                            r_op      <= 3'(op_i - OP_MUL);
                            r_neg     <= (op_i == OP_REM) ? w_n1 : (w_n1 ^ w_n2);
                            r_ovr     <= w_div0 || w_sovf;
                            r_ovr_val <= w_ovr_val;
                        end else begin
                            r_rd        <= w_alu;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_ITER: begin
                    r_hi    <= w_step_hi;
                    r_lo    <= w_step_lo;
                    r_count <= r_count + 1'b1;
                    if (r_count == CNT_LAST)
                        r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_rd        <= w_fix;
                    r_out_valid <= 1'b1;
                    r_count     <= '0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/k423_ex_alu_mc.md
# k423_ex_alu_mc

Parametrised, handshaked execute-stage integer unit for the k423 core, covering RV32I/RV64I-style ALU operations and the M-extension multiply/divide family. Single-cycle ops complete with one registered stage at full throughput. MUL*/DIV*/REM* run on a shared iterative datapath, one bit per cycle. The block sits in the ex stage between id-stage operand delivery and the ex/mem pipeline register, and it back-pressures id through a valid/ready pair.

## Interface
- XLEN, 32: datapath width; legal values are 32 or 64.
- SHAMT_W, $clog2(XLEN): shift-amount width.
- clk_i  in  1  core clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- in_valid_i  in  1  id stage presents an operation.
- in_ready_o  out  1  block can accept the operation this cycle.
- op_i  in  5  operation code:
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 LUI, 11 AUIPC
  - 12 MUL, 13 MULH, 14 MULHSU, 15 MULHU, 16 DIV, 17 DIVU, 18 REM, 19 REMU
  - 20-31 reserved
- use_imm_i  in  1  operand 2 = imm_i; otherwise operand 2 = rs2_i.
- pc_i  in  XLEN  instruction PC; used by AUIPC only.
- rs1_i  in  XLEN  source operand 1.
- rs2_i  in  XLEN  source operand 2.
- imm_i  in  XLEN  sign-extended immediate.
- flush_i  in  1  pipeline kill.
- out_valid_o  out  1  rd_o holds a result.
- out_ready_i  in  1  downstream consumes the result.
- rd_o  out  XLEN  result.
- busy_o  out  1  a multi-cycle op is in flight.

## Operation
- Operand selection:
  - op1 = pc_i for AUIPC, else rs1_i.
  - op2 = use_imm_i ? imm_i : rs2_i.
  - Shift amount = op2[SHAMT_W-1:0]; upper bits are ignored.
- Acceptance: accept = in_valid_i & in_ready_o & ~flush_i.
- in_ready_o = (state==IDLE) & (~out_valid_o | out_ready_i). It does not depend on flush_i.
- Single-cycle ops (0-11, reserved):
  - Result is computed from the inputs and registered into rd_o at the accept edge; out_valid_o is set.
  - SLT is signed compare, SLTU unsigned; result is 1 or 0 zero-extended.
  - SRA fills with op1[XLEN-1].
  - LUI returns imm_i.
  - Reserved codes return 0.
  - Arithmetic wraps modulo 2^XLEN.
- Multi-cycle ops (12-19): operands are latched at accept. Operands are converted to magnitudes per signedness (MULH: both signed; MULHSU: op1 signed; DIV/REM: both signed).
- State machine IDLE -> ITER -> FIX -> IDLE.
  - IDLE: accept of a multi-cycle op -> ITER, count=0, busy_o=1.
  - ITER: one shift-add (MUL*) or restoring-subtract (DIV*) step per cycle. count increments; at count==XLEN-1 -> FIX.
  - FIX: applies sign correction, selects the low/high product, quotient or remainder, writes rd_o, sets out_valid_o -> IDLE.
  - MUL returns the low XLEN bits of the 2*XLEN product; MULH* return the high XLEN bits.
- Division corner cases, detected at accept and overriding the FIX result (latency is unchanged):
  - Divisor 0: DIV/DIVU = all ones; REM/REMU = dividend.
  - DIV of most-negative value by -1: quotient = most-negative value, REM = 0.
  - Signed remainder takes the dividend's sign.
- Output hold: rd_o and out_valid_o hold until out_valid_o & out_ready_i. On that handshake with no new accept, out_valid_o clears next edge. A same-edge accept of a single-cycle op reloads rd_o with out_valid_o staying 1.
- Flush: flush_i=1 on an edge forces state=IDLE, out_valid_o=0, busy_o=0, count=0. Any in-flight op or pending result is discarded. rd_o keeps its value.

## Timing
- Reset (async assert, sync-safe deassert): out_valid_o=0, rd_o=0, busy_o=0, state=IDLE, count=0; therefore in_ready_o=1.
- Single-cycle latency: 1 edge. Throughput: 1 op/cycle while out_ready_i=1.
- Multi-cycle latency: XLEN+1 edges from the accept edge to out_valid_o high. This is 33 for XLEN=32, regardless of operand values or corner cases.
- in_ready_o is 0 during ITER/FIX and while out_valid_o=1 & out_ready_i=0.
- Reset mid-ITER: the op is abandoned and no result is produced.
- Flush on the FIX edge: the result is not written.
- Flush on the same edge as out_ready_i: out_valid_o=0 next cycle, with no double consumption.

## Test plan
- Back-to-back single-cycle ops with out_ready_i=1 and XLEN=32:
  - ADD 5+7, SUB 3-5, SLT -1<1, SLTU -1<1 -> rd_o = 12, 0xFFFFFFFE, 1, 0 on consecutive cycles.
  - in_ready_o stays 1 throughout.
- Shifts with rs1=0x80000010, use_imm_i=1, imm_i=0xFFFFFFE4 (shamt 4):
  - SLL -> 0x00000100.
  - SRL -> 0x08000001.
  - SRA -> 0xF8000001.
- MULH, rs1=0x80000000, rs2=0xFFFFFFFF:
  - rd_o=0x00000000 exactly 33 edges after accept.
  - busy_o=1 for edges 1-33.
  - in_ready_o=0 until the result is consumed.
- Divide corner cases:
  - DIV 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
  - DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
- Back-pressure:
  - out_ready_i=0 for 5 cycles after a result -> rd_o and out_valid_o stable, in_ready_o=0.
  - out_ready_i=1 -> handshake; a new op is accepted in the same cycle.
- Abort paths:
  - flush_i at ITER count 10 -> busy_o=0 and out_valid_o=0 next cycle; a following ADD completes in 1 edge.
  - Async rst_n_i low mid-DIVU -> all outputs reset immediately.
